enemy_fire_scheduler: RTL

- Schedules enemy shots during GAME_PLAYING. Every fire period it picks the next alive enemy in round-robin order and the lowest free enemy-bullet slot.
- It issues one fire request per period to the bullet datapath over a valid/ack handshake.
- It sits beside the bullet generate/move logic inside the game top and replaces ad-hoc per-enemy firing.

---
 rtl/enemy_fire_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/enemy_fire_scheduler.sv
// enemy_fire_scheduler
// Picks which enemy shoots and which bullet slot it fills while the game is
// being played. Once per fire period the next alive enemy is chosen in
// round-robin order, then the lowest free bullet slot. The result is offered
// to the bullet datapath over a valid/ack handshake. The fire period shortens
// as the stage phase advances.
//
// Ports
//   i_Clock            system clock, all state changes on posedge
//   i_Reset            asynchronous, active-low reset
//   i_Tick             one-clock game tick strobe
//   i_Enable           high while the game is in the playing state
//   i_PhaseState       stage phase (0..3), shortens the fire period
//   i_EnemyState       alive mask, bit k set = enemy k alive
//   i_EnemyBulletState busy mask, bit s set = bullet slot s in use
//   i_FireAck          datapath accepted the pending request
//   o_FireValid        fire request pending
//   o_FireEnemy        index of the shooting enemy
//   o_FireSlot         index of the bullet slot to fill
//   o_Drop             one-clock pulse: a shot was skipped, no free slot
//   o_Busy             high while scanning or issuing

module enemy_fire_scheduler #(
  parameter int MAX_ENEMY        = 15,
  parameter int MAX_ENEMY_BULLET = 31,
  parameter int FIRE_PERIOD_BASE = 12,
  parameter int PHASE_STEP       = 2
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset,
  input  logic                        i_Tick,
  input  logic                        i_Enable,
  input  logic [1:0]                  i_PhaseState,
  input  logic [MAX_ENEMY-1:0]        i_EnemyState,
  input  logic [MAX_ENEMY_BULLET-1:0] i_EnemyBulletState,
  input  logic                        i_FireAck,
  output logic                        o_FireValid,
  output logic [3:0]                  o_FireEnemy,
  output logic [4:0]                  o_FireSlot,
  output logic                        o_Drop,
  output logic                        o_Busy
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    SCAN_E,
    SCAN_S,
    ISSUE
  } stateType;

  stateType   state;
  logic [3:0] rr;
  logic [3:0] cnt;
  logic [3:0] scanCnt;
  logic [3:0] rrNext;
  logic [3:0] reloadValue;
  logic       freeFound;
  logic [4:0] freeSlot;

  // Tick counter reload value: one less than the period, because the
  // counter expires on the tick that finds it already at zero.
  always_comb begin
    reloadValue = 4'(FIRE_PERIOD_BASE - 1 - PHASE_STEP * int'(i_PhaseState));
  end

  // Round-robin pointer advance, wrapping after the last enemy.
  always_comb begin
    rrNext = (rr == 4'(MAX_ENEMY - 1)) ? 4'd0 : rr + 4'd1;
  end

  // Lowest free bullet slot. Walking from the top down lets the lowest
  // free index win the last assignment.
  always_comb begin
    freeFound = 1'b0;
    freeSlot  = 5'd0;
    for (int s = MAX_ENEMY_BULLET - 1; s >= 0; s--) begin
      if (!i_EnemyBulletState[s]) begin
        freeFound = 1'b1;
        freeSlot  = 5'(s);
      end
    end
  end

  // Main scheduler state machine. All outputs are registered here. Disable
  // takes priority over everything, including an ack in the same clock, and
  // leaves the round-robin pointer untouched so firing order resumes after
  // a pause.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state       <= IDLE;
      rr          <= 4'd0;
      cnt         <= 4'd0;
      scanCnt     <= 4'd0;
      o_FireValid <= 1'b0;
      o_FireEnemy <= 4'd0;
      o_FireSlot  <= 5'd0;
      o_Drop      <= 1'b0;
      o_Busy      <= 1'b0;
    end else begin
      o_Drop <= 1'b0;
      if (!i_Enable) begin
        state       <= IDLE;
        o_FireValid <= 1'b0;
        o_FireEnemy <= 4'd0;
        o_FireSlot  <= 5'd0;
        o_Busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= reloadValue;
            state <= WAIT;
          end
          WAIT: begin
            if (i_Tick) begin
              if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
              end else begin
                scanCnt <= 4'd0;
                state   <= SCAN_E;
                o_Busy  <= 1'b1;
              end
            end
          end
          SCAN_E: begin
            // The pointer moves on every candidate, hit or miss, so a full
            // sweep of dead enemies returns it to where it started.
            rr <= rrNext;
            if (i_EnemyState[rr]) begin
              o_FireEnemy <= rr;
              state       <= SCAN_S;
            end else if (scanCnt == 4'(MAX_ENEMY - 1)) begin
              cnt    <= reloadValue;
              state  <= WAIT;
              o_Busy <= 1'b0;
            end else begin
              scanCnt <= scanCnt + 4'd1;
            end
          end
          SCAN_S: begin
            // A failed slot search still consumes this enemy's turn.
            if (freeFound) begin
              o_FireSlot  <= freeSlot;
              o_FireValid <= 1'b1;
              state       <= ISSUE;
            end else begin
              o_Drop <= 1'b1;
              cnt    <= reloadValue;
              state  <= WAIT;
              o_Busy <= 1'b0;
            end
          end
          ISSUE: begin
            if (i_FireAck) begin
              o_FireValid <= 1'b0;
              cnt         <= reloadValue;
              state       <= WAIT;
              o_Busy      <= 1'b0;
            end
          end
          default: begin
            state       <= IDLE;
            o_FireValid <= 1'b0;
            o_Busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
